branch_resolver: RTL
====================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 Parameter IDX_BITS, default 4, SHALL set the counter table to 2**IDX_BITS entries, indexed by pc[IDX_BITS+1:2].
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two), SHALL set the number of in-flight predictions held.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pred_valid  input  1  fetch issued a predicted branch this cycle.
REQ-006 pred_pc  input  32  PC of that branch.
REQ-007 pred_target  input  32  next PC that fetch chose.
REQ-008 pred_ready  output  1  FIFO not full.
REQ-009 res_valid  input  1  EX resolves the oldest in-flight branch.
REQ-010 res_taken  input  1  actual direction.
REQ-011 res_target  input  32  computed taken target (PC+imm).
REQ-012 lookup_pc  input  32  fetch PC for counter read.
REQ-013 lookup_state  output  2  counter at lookup_pc index (combinational), feeds predictor state_in.
REQ-014 flush  output  1  registered one-cycle mispredict pulse.
REQ-015 redirect_pc  output  32  correct next PC, valid while flush=1.
REQ-016 res_err  output  1  sticky: res_valid arrived with FIFO empty.
REQ-017 mispredict_cnt  output  16  saturating mispredict count.

Function
REQ-018 Push SHALL occur when pred_valid && pred_ready && !flush && !mispredict_now, storing {pred_pc, pred_target}.
REQ-019 Pop SHALL occur when res_valid && FIFO non-empty; res_valid with FIFO empty SHALL set res_err and change nothing else.
REQ-020 Actual next PC SHALL be res_taken ? res_target : head.pc+4, 32-bit wrap-around.
REQ-021 mispredict_now SHALL be pop && (actual next PC != head.target).
REQ-022 On mispredict_now, the cycle after SHALL have flush=1, redirect_pc=actual next PC, FIFO emptied (head and all younger entries discarded), same-cycle push dropped.
REQ-023 On a correct pop, flush SHALL be 0 next cycle and redirect_pc SHALL hold its last value.
REQ-024 Push and pop in the same cycle without mispredict SHALL both take effect; count unchanged; allowed when FIFO is full.
REQ-025 On every pop the counter at head.pc index SHALL update: taken -> increment, not taken -> decrement, saturating at strongly_taken / strongly_NT.
REQ-026 lookup_state SHALL return the pre-update value when lookup index equals the index written that cycle (no bypass).
REQ-027 mispredict_cnt SHALL increment per mispredict and hold at 16'hFFFF.
REQ-028 pred_ready SHALL be 0 exactly when FIFO holds FIFO_DEPTH entries.

Reset
REQ-029 rst SHALL set every counter to slightly_taken, FIFO empty, flush=0, redirect_pc=0, res_err=0, mispredict_cnt=0.
REQ-030 rst asserted mid-operation SHALL discard all in-flight entries with no flush pulse emitted.

Structure
REQ-031 Counter encodings (strongly_NT=2'b00, slightly_NT=2'b01, slightly_taken=2'b10, strongly_taken=2'b11) SHALL live in the shared defines file.
REQ-032 The in-flight buffer SHALL be a sub-module branch_fifo (sync FIFO with push, pop, clear, full, empty).

Verification
REQ-033 Reset, lookup_pc=0x40 -> lookup_state=2'b10; pred_ready=1; flush=0.
REQ-034 Push {pc=0x100, target=0x104}, resolve res_taken=0 -> no flush; counter[0] goes 10->01.
REQ-035 Push {pc=0x100, target=0x104}, resolve res_taken=1, res_target=0x180 -> next cycle flush=1, redirect_pc=0x180, mispredict_cnt=1, FIFO empty.
REQ-036 Push 4 entries -> pred_ready=0; push+correct pop same cycle -> still 4 entries, pred_ready=0.
REQ-037 Three taken resolutions at pc=0x200 from reset -> counter 10->11->11->11 (saturation).
REQ-038 res_valid with FIFO empty -> res_err=1 and stays 1 until rst; mispredict with simultaneous push -> pushed entry absent.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: 2-bit direction counters and the
// in-flight prediction record carried from fetch to EX.
package branch_resolver_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
  } inflight_t;

  // Saturating step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
    return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_fifo.sv
// Synchronous FIFO of in-flight predictions; clear flushes all entries and
// overrides any push/pop in the same cycle. Head is read combinationally.
module branch_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  inflight_t din,
  output inflight_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  inflight_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; a push into a full FIFO only happens alongside a
  // pop, so overwriting the slot being read is safe.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches in order: checks EX outcome against the
// predicted next PC, trains the 2-bit counter table, and flushes on mispredict.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int IDX_BITS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic [31:0] pred_target,
  output logic        pred_ready,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] lookup_pc,
  output logic [1:0]  lookup_state,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        res_err,
  output logic [15:0] mispredict_cnt
);

  localparam int ENTRIES = 2**IDX_BITS;

  ctr_t                ctr_tbl [ENTRIES];
  inflight_t           head;
  logic                full, empty;
  logic                pop, push, mispredict_now;
  logic [31:0]         actual_pc;
  logic [IDX_BITS-1:0] lk_idx, hd_idx;
  logic                unused_bits;

  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign hd_idx = head.pc[IDX_BITS+1:2];
  assign unused_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                         head.pc[31:IDX_BITS+2], head.pc[1:0]};

  assign pop            = res_valid && !empty;
  assign actual_pc      = res_taken ? res_target : head.pc + 32'd4;
  assign mispredict_now = pop && (actual_pc != head.target);
  // A full FIFO still accepts when the head retires the same cycle.
  assign push       = pred_valid && (!full || pop) && !flush && !mispredict_now;
  assign pred_ready = !full;

  branch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (mispredict_now),
    .push  (push),
    .pop   (pop),
    .din   ('{pc: pred_pc, target: pred_target}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // No write bypass: lookup sees the value before this cycle's update.
  assign lookup_state = ctr_tbl[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= WEAK_T;
    end else if (pop) begin
      ctr_tbl[hd_idx] <= ctr_next(ctr_tbl[hd_idx], res_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      res_err        <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      flush <= mispredict_now;
      if (mispredict_now) begin
        redirect_pc <= actual_pc;
        if (mispredict_cnt != 16'hFFFF) mispredict_cnt <= mispredict_cnt + 16'd1;
      end
      if (res_valid && empty) res_err <= 1'b1;
    end
  end

endmodule
